pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage core. It consumes the load-use request from hazard detection, the EX-stage jump, multi-cycle-op status and the data-bus wait. From these it drives the hold/flush strobes for PC, IF_ID, ID_EX and EX_MEM, plus the PC redirect. It sits beside the pipeline registers and is the single owner of stall and flush priority.

---
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect arbitration for the 5-stage core.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_hazard,
  input  logic              ex_jump,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              ex_div_start,
  input  logic              ex_div_done,
  input  logic              mem_wait,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              id_ex_hold,
  output logic              ex_mem_hold,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              div_err,
  output logic [1:0]        state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_DIV = 2'd1,
    ST_BUS = 2'd2
  } state_e;

  // Abort when the incremented watchdog reaches this value; together with
  // the issue cycle the stall then spans exactly DIV_TIMEOUT cycles.
  localparam logic [6:0] WD_LAST = 7'(DIV_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [6:0]          wd_q, wd_d;
  logic [6:0]          wd_inc;

  logic pc_hold_c, if_id_hold_c, id_ex_hold_c, ex_mem_hold_c;
  logic if_id_flush_c, id_ex_flush_c, redirect_c, div_err_c;
  logic [ADDR_W-1:0] redirect_addr_c;

  // Priority arbitration: next state and raw strobes.
  always_comb begin
    state_d         = state_q;
    pend_v_d        = pend_v_q;
    pend_addr_d     = pend_addr_q;
    wd_d            = wd_q;
    wd_inc          = wd_q + 7'd1;
    pc_hold_c       = 1'b0;
    if_id_hold_c    = 1'b0;
    id_ex_hold_c    = 1'b0;
    ex_mem_hold_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    redirect_c      = 1'b0;
    redirect_addr_c = '0;
    div_err_c       = 1'b0;

    if (mem_wait) begin
      pc_hold_c     = 1'b1;
      if_id_hold_c  = 1'b1;
      id_ex_hold_c  = 1'b1;
      ex_mem_hold_c = 1'b1;
      if (ex_jump) begin
        pend_v_d    = 1'b1;
        pend_addr_d = ex_jump_addr;
      end
      if (state_q == ST_RUN) state_d = ST_BUS;
    end else if (state_q == ST_DIV) begin
      if (!ex_div_done) begin
        pc_hold_c    = 1'b1;
        if_id_hold_c = 1'b1;
        id_ex_hold_c = 1'b1;
        if (wd_inc == WD_LAST) begin
          div_err_c = 1'b1;
          state_d   = ST_RUN;
          wd_d      = '0;
        end else begin
          wd_d = wd_inc;
        end
      end else begin
        state_d = ST_RUN;
        wd_d    = '0;
      end
    end else begin
      // RUN, or BUS whose wait just dropped: both resolve the lower rules.
      state_d = ST_RUN;
      if (ex_jump || pend_v_q) begin
        redirect_c      = 1'b1;
        if_id_flush_c   = 1'b1;
        id_ex_flush_c   = 1'b1;
        redirect_addr_c = pend_v_q ? pend_addr_q : ex_jump_addr;
        pend_v_d        = 1'b0;
      end else if (ex_div_start) begin
        pc_hold_c    = 1'b1;
        if_id_hold_c = 1'b1;
        id_ex_hold_c = 1'b1;
        state_d      = ST_DIV;
        wd_d         = '0;
      end else if (ld_hazard) begin
        pc_hold_c     = 1'b1;
        if_id_hold_c  = 1'b1;
        id_ex_flush_c = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      wd_q        <= wd_d;
    end
  end

  // Strobes are forced low while reset is held so nothing leaks out.
  assign pc_hold       = rst_n & pc_hold_c;
  assign if_id_hold    = rst_n & if_id_hold_c;
  assign id_ex_hold    = rst_n & id_ex_hold_c;
  assign ex_mem_hold   = rst_n & ex_mem_hold_c;
  assign if_id_flush   = rst_n & if_id_flush_c;
  assign id_ex_flush   = rst_n & id_ex_flush_c;
  assign redirect      = rst_n & redirect_c;
  assign redirect_addr = rst_n ? redirect_addr_c : '0;
  assign div_err       = rst_n & div_err_c;
  assign state         = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + 32'd1;
    if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected strobes computed
// by a behavioural model; a negedge monitor pops and compares.
module tb_pipe_ctrl;
  localparam int unsigned DIV_TIMEOUT = 64;
  localparam int unsigned ADDR_W      = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_hazard, ex_jump, ex_div_start, ex_div_done, mem_wait;
  logic [ADDR_W-1:0] ex_jump_addr;
  logic              pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic              if_id_flush, id_ex_flush, redirect, div_err;
  logic [ADDR_W-1:0] redirect_addr;
  logic [1:0]        state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       stall_cnt, flush_cnt;
`endif

  pipe_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ld_hazard(ld_hazard), .ex_jump(ex_jump),
    .ex_jump_addr(ex_jump_addr), .ex_div_start(ex_div_start),
    .ex_div_done(ex_div_done), .mem_wait(mem_wait), .pc_hold(pc_hold),
    .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .redirect(redirect),
    .redirect_addr(redirect_addr), .div_err(div_err), .state(state)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  flags;   // pc,ifid,idex,exmem holds, ifid,idex flush, redirect, div_err, state[1:0]
    logic        chk_addr;
    logic [31:0] raddr;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Behavioural model: mode flags, stall length incl. issue cycle, pending targets.
  bit          m_div, m_bus;
  int unsigned m_stall_len;
  logic [31:0] m_pend[$];
  longint      m_scnt, m_fcnt;

  task automatic step(input logic rst, input logic ld, input logic jmp,
                      input logic [31:0] ja, input logic ds, input logic dd,
                      input logic mw);
    logic ph, ih, eh, mh, ifl, efl, rd, err;
    logic [1:0] st;
    logic [31:0] ra;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; ld_hazard = ld; ex_jump = jmp; ex_jump_addr = ja;
    ex_div_start = ds; ex_div_done = dd; mem_wait = mw;
    {ph, ih, eh, mh, ifl, efl, rd, err} = '0;
    ra = '0;
    st = m_div ? 2'd1 : (m_bus ? 2'd2 : 2'd0);
    e.scnt = 32'(m_scnt);
    e.fcnt = 32'(m_fcnt);
    if (!rst) begin
      m_div = 0; m_bus = 0; m_pend.delete(); m_scnt = 0; m_fcnt = 0;
      st = 2'd0; e.scnt = '0; e.fcnt = '0;
    end else begin
      if (mw) begin
        {ph, ih, eh, mh} = 4'b1111;
        if (jmp) begin m_pend.delete(); m_pend.push_back(ja); end
        if (!m_div) m_bus = 1;
      end else if (m_div && !dd) begin
        {ph, ih, eh} = 3'b111;
        m_stall_len++;
        if (m_stall_len == DIV_TIMEOUT) begin err = 1; m_div = 0; end
      end else if (m_div) begin
        m_div = 0;
      end else begin
        m_bus = 0;
        if (jmp || m_pend.size() > 0) begin
          rd = 1; ifl = 1; efl = 1;
          ra = (m_pend.size() > 0) ? m_pend[0] : ja;
          m_pend.delete();
        end else if (ds) begin
          {ph, ih, eh} = 3'b111;
          m_div = 1; m_stall_len = 1;
        end else if (ld) begin
          ph = 1; ih = 1; efl = 1;
        end
      end
      if (ph && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (ifl && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
    end
    e.flags    = {ph, ih, eh, mh, ifl, efl, rd, err, st};
    e.chk_addr = rd;
    e.raddr    = ra;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT strobes against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [9:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush,
             id_ex_flush, redirect, div_err, state};
      cyc++;
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL strobes cyc=%0d got=%b exp=%b", cyc, got, e.flags);
      end
      if (e.chk_addr) begin
        checks++;
        if (redirect_addr !== e.raddr) begin
          errors++;
          $display("FAIL redirect_addr cyc=%0d got=%h exp=%h", cyc, redirect_addr, e.raddr);
        end
      end
`ifdef PIPE_CTRL_PERF_EN
      checks++;
      if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
        errors++;
        $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stall_cnt,
                 flush_cnt, e.scnt, e.fcnt);
      end
`endif
    end
  end

  initial begin
    logic jmp, dd;
    rst_n = 1'b0; ld_hazard = 0; ex_jump = 0; ex_jump_addr = '0;
    ex_div_start = 0; ex_div_done = 0; mem_wait = 0;
    // Reset with busy inputs: everything must read zero.
    step(0, 1, 1, 32'h1234, 1, 0, 1);
    step(0, 1, 0, 32'h0, 0, 1, 1);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    // Load-use bubble.
    step(1, 1, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    // Jump squashes a simultaneous load-use.
    step(1, 1, 1, 32'h0000_0100, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    // Bus wait with jump latched in its first cycle.
    step(1, 0, 1, 32'hCAFE_0040, 0, 0, 1);
    step(1, 0, 0, 32'h0, 0, 0, 1);
    step(1, 0, 0, 32'h0, 0, 0, 1);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    // Divide finishing 10 cycles after issue.
    step(1, 0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 1, 0);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    // Divide that never finishes: watchdog abort.
    step(1, 0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 66; i++) step(1, 0, 0, 32'h0, 0, 0, 0);
    // ex_div_done in RUN is ignored.
    step(1, 0, 0, 32'h0, 0, 1, 0);
    // Reset asserted mid-divide.
    step(1, 0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      jmp = ($urandom_range(7) == 0) && !m_div;
      dd  = m_div ? ($urandom_range(15) == 0) : ($urandom_range(31) == 0);
      step(($urandom_range(399) != 0), ($urandom_range(3) == 0), jmp, $urandom,
           ($urandom_range(15) == 0), dd, ($urandom_range(3) == 0));
    end
    step(1, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
